// File: rtl/fetch_unit.sv
// fetch_unit: single-outstanding instruction fetch FSM with redirect/kill handling
module fetch_unit #(
  parameter int DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [DATA_WIDTH-1:0] imem_req_addr,
  input  logic                  imem_resp_valid,
  input  logic [DATA_WIDTH-1:0] imem_resp_data,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  output logic [DATA_WIDTH-1:0] instruction,
  output logic [DATA_WIDTH-1:0] inst_pc,
  input  logic                  redirect_valid,
  input  logic [DATA_WIDTH-1:0] redirect_pc
);
  localparam logic [1:0] S_REQ = 2'd0, S_WAIT = 2'd1, S_HOLD = 2'd2;
  logic [1:0] state, state_n;
  logic [DATA_WIDTH-1:0] pc, pc_n;
  logic kill, kill_n, hs, got, take;
  assign imem_req_valid = state == S_REQ;
  assign imem_req_addr = pc;
  assign inst_valid = state == S_HOLD;
  always_comb begin
    hs = state == S_REQ && imem_req_ready;
    got = state == S_WAIT && imem_resp_valid;
    take = got && !kill && !redirect_valid;
    state_n = hs ? S_WAIT :
              got ? (take ? S_HOLD : S_REQ) :
              (state == S_HOLD && (inst_ready || redirect_valid)) ? S_REQ : state;
    kill_n = hs ? redirect_valid : got ? 1'b0 : state == S_WAIT ? (kill | redirect_valid) : kill;
    pc_n = redirect_valid ? (redirect_pc & ~DATA_WIDTH'(3)) : take ? pc + DATA_WIDTH'(4) : pc;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= S_REQ;
      pc <= RESET_PC;
      kill <= 1'b0;
      instruction <= '0;
      inst_pc <= '0;
    end else begin
      state <= state_n;
      pc <= pc_n;
      kill <= kill_n;
      if (take) begin
        instruction <= imem_resp_data;
        inst_pc <= pc;
      end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed and random checks of fetch_unit against a transaction-level model
module tb_fetch_unit;
  logic clk = 0, rst = 1;
  logic req_valid, req_ready, resp_valid, inst_valid, inst_ready, redirect_valid;
  logic [31:0] req_addr, resp_data, instruction, inst_pc, redirect_pc;
  logic req_valid1, req_ready1, resp_valid1, inst_valid1, inst_ready1;
  logic [31:0] req_addr1, resp_data1, instruction1, inst_pc1;
  int n_chk = 0, n_pass = 0;
  bit pend, stale, have;
  logic [31:0] m_pc, h_inst, h_pc;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(req_valid), .imem_req_ready(req_ready), .imem_req_addr(req_addr),
    .imem_resp_valid(resp_valid), .imem_resp_data(resp_data),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .instruction(instruction), .inst_pc(inst_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  fetch_unit #(.DATA_WIDTH(32), .RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst(rst),
    .imem_req_valid(req_valid1), .imem_req_ready(req_ready1), .imem_req_addr(req_addr1),
    .imem_resp_valid(resp_valid1), .imem_resp_data(resp_data1),
    .inst_valid(inst_valid1), .inst_ready(inst_ready1), .instruction(instruction1), .inst_pc(inst_pc1),
    .redirect_valid(1'b0), .redirect_pc(32'h0)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    pend = 0; stale = 0; have = 0; m_pc = 32'h0;
  endtask

  task automatic cyc(input logic rdy, input logic rv, input logic [31:0] d,
                     input logic ir, input logic rd, input logic [31:0] rp);
    bit req;
    @(negedge clk);
    check("req_valid", req_valid, !pend && !have);
    check("req_addr", req_addr, m_pc);
    check("inst_valid", inst_valid, have);
    if (have) begin
      check("instruction", instruction, h_inst);
      check("inst_pc", inst_pc, h_pc);
    end
    req_ready = rdy; resp_valid = rv; resp_data = d;
    inst_ready = ir; redirect_valid = rd; redirect_pc = rp;
    @(posedge clk);
    req = !pend && !have;
    if (req && rdy) begin
      pend = 1; stale = rd;
    end else if (pend && rv) begin
      pend = 0;
      if (!stale && !rd) begin
        have = 1; h_inst = d; h_pc = m_pc; m_pc += 4;
      end
      stale = 0;
    end else if (pend && rd) stale = 1;
    else if (have && (ir || rd)) have = 0;
    if (rd) m_pc = rp & ~32'h3;
  endtask

  initial begin
    req_ready = 0; resp_valid = 0; resp_data = 0; inst_ready = 0; redirect_valid = 0; redirect_pc = 0;
    req_ready1 = 0; resp_valid1 = 0; resp_data1 = 0; inst_ready1 = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_req_valid", req_valid, 1);
    check("rst_inst_valid", inst_valid, 0);
    check("rst_addr", req_addr, 32'h0);
    check("rst_instruction", instruction, 32'h0);
    check("rst_inst_pc", inst_pc, 32'h0);
    @(negedge clk) rst = 0;
    // basic fetch at reset pc
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 1, 32'h0000_2083, 0, 0, 0);
    #1;
    check("basic_valid", inst_valid, 1);
    check("basic_inst", instruction, 32'h0000_2083);
    check("basic_pc", inst_pc, 32'h0);
    for (int i = 0; i < 5; i++) begin
      cyc(1, 1, 32'hDEAD_BEEF, 0, 0, 0);
      #1;
      check("stall_inst", instruction, 32'h0000_2083);
      check("stall_pc", inst_pc, 32'h0);
      check("stall_req", req_valid, 0);
    end
    cyc(0, 0, 0, 1, 0, 0);
    #1;
    check("next_addr", req_addr, 32'h4);
    check("next_req", req_valid, 1);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 1, 32'h11, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);
    // redirect while waiting, stale response arrives later
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 32'h103);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 1, 32'h22, 0, 0, 0);
    #1;
    check("kill_inst_valid", inst_valid, 0);
    check("kill_addr", req_addr, 32'h100);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 1, 32'h33, 0, 0, 0);
    #1;
    check("redir_inst_pc", inst_pc, 32'h100);
    check("redir_inst", instruction, 32'h33);
    cyc(0, 0, 0, 1, 0, 0);
    // redirect coincident with response
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 1, 32'h44, 0, 1, 32'h2000);
    #1;
    check("same_inst_valid", inst_valid, 0);
    check("same_addr", req_addr, 32'h2000);
    // async reset in S_WAIT with responses during and after
    cyc(1, 0, 0, 0, 0, 0);
    @(negedge clk);
    #2 rst = 1; resp_valid = 1; resp_data = 32'h55; req_ready = 0; inst_ready = 1;
    #1;
    check("async_req_valid", req_valid, 1);
    check("async_addr", req_addr, 32'h0);
    check("async_inst_valid", inst_valid, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, 32'h66, 1, 0, 0);
      #1;
      check("post_rst_inst_valid", inst_valid, 0);
    end
    check("post_rst_addr", req_addr, 32'h0);
    // pc wrap on the high reset-pc instance
    @(negedge clk) req_ready1 = 1;
    @(negedge clk) begin req_ready1 = 0; resp_valid1 = 1; resp_data1 = 32'h13; end
    @(negedge clk);
    check("wrap_valid", inst_valid1, 1);
    check("wrap_inst_pc", inst_pc1, 32'hFFFF_FFFC);
    resp_valid1 = 0; inst_ready1 = 1;
    @(negedge clk);
    check("wrap_addr", req_addr1, 32'h0);
    check("wrap_req", req_valid1, 1);
    inst_ready1 = 0;
    // random traffic
    for (int i = 0; i < 3000; i++)
      cyc($urandom_range(0, 1), ($urandom % 3) == 0, $urandom, $urandom_range(0, 1),
          ($urandom % 10) == 0, $urandom);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The module SHALL have parameter DATA_WIDTH, default 32, giving the instruction, address and PC width.
REQ-002 The module SHALL have parameter RESET_PC, default 32'h0000_0000, giving the PC loaded on reset.
REQ-003 Port clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-004 Port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 Port imem_req_valid, output, 1 bit: fetch request to instruction memory.
REQ-006 Port imem_req_ready, input, 1 bit: memory accepts the request this cycle.
REQ-007 Port imem_req_addr, output, DATA_WIDTH: byte address of the request.
REQ-008 Port imem_resp_valid, input, 1 bit: response data is valid this cycle.
REQ-009 Port imem_resp_data, input, DATA_WIDTH: fetched instruction word.
REQ-010 Port inst_valid, output, 1 bit: instruction presented to the decoder.
REQ-011 Port inst_ready, input, 1 bit: decoder consumes the instruction this cycle.
REQ-012 Port instruction, output, DATA_WIDTH: raw instruction word fed to the decoder.
REQ-013 Port inst_pc, output, DATA_WIDTH: address of the presented instruction.
REQ-014 Port redirect_valid, input, 1 bit: control-flow change request.
REQ-015 Port redirect_pc, input, DATA_WIDTH: new fetch target.

Function
REQ-016 The FSM SHALL have exactly three states: S_REQ (issue request), S_WAIT (awaiting response), S_HOLD (presenting instruction).
REQ-017 In S_REQ, imem_req_valid=1 and imem_req_addr=pc; on imem_req_ready=1 the FSM SHALL go to S_WAIT, else stay in S_REQ.
REQ-018 In S_WAIT, on imem_resp_valid=1 with kill=0, the block SHALL register instruction=imem_resp_data and inst_pc=pc, set pc<=pc+4, and go to S_HOLD.
REQ-019 In S_HOLD, inst_valid SHALL be 1; on inst_ready=1 the FSM SHALL go to S_REQ; otherwise instruction and inst_pc SHALL stay stable.
REQ-020 imem_req_valid SHALL be 0 outside S_REQ and inst_valid SHALL be 0 outside S_HOLD; at most one memory request is outstanding.
REQ-021 imem_resp_valid outside S_WAIT SHALL be ignored.
REQ-022 pc+4 SHALL wrap modulo 2^DATA_WIDTH; redirect_pc[1:0] SHALL be forced to 2'b00 when loaded.
REQ-023 redirect_valid=1 SHALL load pc<=redirect_pc in every state and has priority over the pc+4 update.
REQ-024 Redirect in S_HOLD: the held instruction is dropped and the FSM goes to S_REQ; a same-cycle inst_ready counts as a completed transfer.
REQ-025 Redirect in S_REQ without imem_req_ready: the FSM stays in S_REQ; the next request uses the new pc.
REQ-026 Redirect in S_REQ with imem_req_ready=1: the old-pc request is issued, the FSM goes to S_WAIT, and kill is set.
REQ-027 Redirect in S_WAIT without imem_resp_valid: kill is set and the FSM stays in S_WAIT.
REQ-028 Redirect in S_WAIT with imem_resp_valid=1: the response is discarded and the FSM goes to S_REQ.
REQ-029 In S_WAIT with kill=1, imem_resp_valid SHALL discard the data, clear kill, and go to S_REQ without changing pc.
REQ-030 Best-case throughput SHALL be one instruction per 3 cycles, with 0-cycle memory latency and inst_ready held 1.

Reset
REQ-031 While rst=1, regardless of clk, the block SHALL set: state=S_REQ, pc=RESET_PC, kill=0, instruction=0, inst_pc=0, inst_valid=0.
REQ-032 Reset asserted mid-transaction SHALL abandon any outstanding request; a later stale response arrives in S_REQ and is ignored per REQ-021.
REQ-033 The first request after reset release SHALL be at RESET_PC.

Verification
REQ-034 Reset release, imem_req_ready=1, response 0x00002083 one cycle later, inst_ready=1 -> inst_valid with instruction=0x00002083, inst_pc=0x0; next request addr=0x4.
REQ-035 inst_ready=0 for 5 cycles in S_HOLD -> instruction/inst_pc stable, imem_req_valid=0 throughout; consumed on the 6th cycle.
REQ-036 Redirect to 0x103 while in S_WAIT, response at pc 0x8 two cycles later -> response discarded, next request addr=0x100, inst_pc of next instruction=0x100.
REQ-037 Redirect and imem_resp_valid in the same cycle -> no inst_valid; next request addr=redirect_pc.
REQ-038 RESET_PC=32'hFFFF_FFFC, one instruction consumed -> next imem_req_addr=0x0 (wrap).
REQ-039 rst asserted in S_WAIT, response delivered during and after reset -> inst_valid never asserts; first post-reset request at RESET_PC.
